// File: rtl/mai_rd_rsp_router_pkg.sv
// Shared types and constants for the MAI read-response router.
package mai_rd_rsp_router_pkg;
  localparam int MAI_TAG_W    = 4;
  localparam int MAI_DATA_W   = 32;
  localparam int MAI_STATUS_W = 2;
  localparam int MAI_LEN_W    = 2;
  localparam int MAI_REM_W    = 4;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_e;

  typedef struct packed {
    logic [MAI_TAG_W-1:0]    tag;
    logic [MAI_DATA_W-1:0]   data;
    logic [MAI_STATUS_W-1:0] status;
    logic                    eod;
  } rsp_beat_t;

  // Burst code 00/01/10/11 -> 1/2/4/8 beats
  function automatic logic [MAI_REM_W-1:0] len_to_beats(input logic [MAI_LEN_W-1:0] len);
    return MAI_REM_W'(1) << len;
  endfunction
endpackage

// File: rtl/mai_rd_rsp_router_if.sv
// Bus bundle of the read-response router: issue tracking, MAC response, IF/DM response ports.
interface mai_rd_rsp_router_if
  import mai_rd_rsp_router_pkg::*;
#(
  parameter int TAG_W  = MAI_TAG_W,
  parameter int DATA_W = MAI_DATA_W
);
  logic                    iIss_Valid;
  logic [TAG_W-1:0]        iIss_Tag;
  logic                    iIss_Src;
  logic [1:0]              iIss_Len;
  logic                    oIss_TagBusy;
  logic                    iMAC_ValidRsp;
  logic [TAG_W-1:0]        iMAC_TagRsp;
  logic [DATA_W-1:0]       iMAC_DataRsp;
  logic [MAI_STATUS_W-1:0] iMAC_StatusRsp;
  logic                    iMAC_EoD;
  logic                    oMAC_ReadyRsp;
  logic                    oIF_ValidRsp,  oDM_ValidRsp;
  logic [TAG_W-1:0]        oIF_TagRsp,    oDM_TagRsp;
  logic [DATA_W-1:0]       oIF_DataRsp,   oDM_DataRsp;
  logic [MAI_STATUS_W-1:0] oIF_StatusRsp, oDM_StatusRsp;
  logic                    oIF_EoD,       oDM_EoD;
  logic                    iIF_ReadyRsp,  iDM_ReadyRsp;
  logic                    oErr_Pulse;
`ifdef MAI_RSP_STATS_EN
  logic [15:0]             oStat_IFBeats, oStat_DMBeats;
  logic [7:0]              oStat_Drops;
`endif

  modport slave (
    input  iIss_Valid, iIss_Tag, iIss_Src, iIss_Len,
    input  iMAC_ValidRsp, iMAC_TagRsp, iMAC_DataRsp, iMAC_StatusRsp, iMAC_EoD,
    input  iIF_ReadyRsp, iDM_ReadyRsp,
    output oIss_TagBusy, oMAC_ReadyRsp, oErr_Pulse,
    output oIF_ValidRsp, oIF_TagRsp, oIF_DataRsp, oIF_StatusRsp, oIF_EoD,
    output oDM_ValidRsp, oDM_TagRsp, oDM_DataRsp, oDM_StatusRsp, oDM_EoD
`ifdef MAI_RSP_STATS_EN
    , output oStat_IFBeats, oStat_DMBeats, oStat_Drops
`endif
  );

  modport master (
    output iIss_Valid, iIss_Tag, iIss_Src, iIss_Len,
    output iMAC_ValidRsp, iMAC_TagRsp, iMAC_DataRsp, iMAC_StatusRsp, iMAC_EoD,
    output iIF_ReadyRsp, iDM_ReadyRsp,
    input  oIss_TagBusy, oMAC_ReadyRsp, oErr_Pulse,
    input  oIF_ValidRsp, oIF_TagRsp, oIF_DataRsp, oIF_StatusRsp, oIF_EoD,
    input  oDM_ValidRsp, oDM_TagRsp, oDM_DataRsp, oDM_StatusRsp, oDM_EoD
`ifdef MAI_RSP_STATS_EN
    , input oStat_IFBeats, oStat_DMBeats, oStat_Drops
`endif
  );
endinterface

// File: rtl/mai_rd_rsp_router_rsp_fifo.sv
// Show-ahead synchronous FIFO; head is read straight from storage, zero while empty.
module mai_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_empty, w_do_push, w_do_pop;

  // Extra pointer MSB tells full from empty when the index bits match
  assign w_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~w_empty;
  assign o_valid   = ~w_empty;
  assign o_data    = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/mai_rd_rsp_router.sv
// Tag-tracked read-response router to IF/DM ports; oErr_Pulse is registered (one cycle after the event).
// Optional MAI_RSP_STATS_EN adds saturating beat/drop counters.
module mai_rd_rsp_router
  import mai_rd_rsp_router_pkg::*;
#(
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int TAG_W          = MAI_TAG_W,
  parameter int DATA_W         = MAI_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  mai_rd_rsp_router_if.slave  bus
);
  localparam int NTAG = 2 ** TAG_W;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic [DATA_W-1:0]       data;
    logic [MAI_STATUS_W-1:0] status;
    logic                    eod;
  } beat_t;

  logic [NTAG-1:0]      r_vld;
  src_e                 r_src [NTAG];
  logic [MAI_REM_W-1:0] r_rem [NTAG];
  logic                 r_err;

  logic                 w_ent_vld, w_sel_full, w_ready, w_acc, w_push, w_drop;
  src_e                 w_ent_src;
  logic [MAI_REM_W-1:0] w_ent_rem;
  logic                 w_last, w_eod, w_free, w_busy, w_alloc, w_err;
  logic                 w_if_full, w_dm_full, w_if_push, w_dm_push, w_if_vld, w_dm_vld;
  beat_t                w_beat, w_if_head, w_dm_head;

  assign w_ent_vld  = r_vld[bus.iMAC_TagRsp];
  assign w_ent_src  = r_src[bus.iMAC_TagRsp];
  assign w_ent_rem  = r_rem[bus.iMAC_TagRsp];
  assign w_sel_full = (w_ent_src == SRC_DM) ? w_dm_full : w_if_full;
  // Unknown tags are always accepted so they can be drained and dropped
  assign w_ready    = resetn & (~w_ent_vld | ~w_sel_full);
  assign w_acc      = bus.iMAC_ValidRsp & w_ready;
  assign w_push     = w_acc & w_ent_vld;
  assign w_drop     = w_acc & ~w_ent_vld;
  assign w_last     = (w_ent_rem == 4'd1);
  assign w_eod      = bus.iMAC_EoD | w_last;
  assign w_free     = w_push & w_eod;
  assign w_if_push  = w_push & (w_ent_src == SRC_IF);
  assign w_dm_push  = w_push & (w_ent_src == SRC_DM);

  // A tag freed by this cycle's final beat may be reissued in the same cycle
  assign w_busy  = r_vld[bus.iIss_Tag] & ~(w_free & (bus.iMAC_TagRsp == bus.iIss_Tag));
  assign w_alloc = bus.iIss_Valid & ~w_busy;
  assign w_err   = w_drop
                 | (w_push & bus.iMAC_EoD & (w_ent_rem > 4'd1))
                 | (w_push & w_last & ~bus.iMAC_EoD)
                 | (bus.iIss_Valid & w_busy);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_free)  r_vld[bus.iMAC_TagRsp] <= 1'b0;
      if (w_alloc) r_vld[bus.iIss_Tag]    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_eod) r_rem[bus.iMAC_TagRsp] <= w_ent_rem - 4'd1;
    if (w_alloc) begin
      r_src[bus.iIss_Tag] <= src_e'(bus.iIss_Src);
      r_rem[bus.iIss_Tag] <= len_to_beats(bus.iIss_Len);
    end
  end

  assign w_beat = '{tag: bus.iMAC_TagRsp, data: bus.iMAC_DataRsp,
                    status: bus.iMAC_StatusRsp, eod: w_eod};

  mai_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH), .W($bits(beat_t))) u_if_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_if_push), .i_data(w_beat),
    .i_pop(bus.iIF_ReadyRsp), .o_full(w_if_full), .o_valid(w_if_vld), .o_data(w_if_head)
  );

  mai_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH), .W($bits(beat_t))) u_dm_fifo (
    .clk(clk), .resetn(resetn), .i_push(w_dm_push), .i_data(w_beat),
    .i_pop(bus.iDM_ReadyRsp), .o_full(w_dm_full), .o_valid(w_dm_vld), .o_data(w_dm_head)
  );

  assign bus.oIss_TagBusy  = w_busy;
  assign bus.oMAC_ReadyRsp = w_ready;
  assign bus.oErr_Pulse    = r_err;
  assign bus.oIF_ValidRsp  = w_if_vld;
  assign bus.oIF_TagRsp    = w_if_head.tag;
  assign bus.oIF_DataRsp   = w_if_head.data;
  assign bus.oIF_StatusRsp = w_if_head.status;
  assign bus.oIF_EoD       = w_if_head.eod;
  assign bus.oDM_ValidRsp  = w_dm_vld;
  assign bus.oDM_TagRsp    = w_dm_head.tag;
  assign bus.oDM_DataRsp   = w_dm_head.data;
  assign bus.oDM_StatusRsp = w_dm_head.status;
  assign bus.oDM_EoD       = w_dm_head.eod;

`ifdef MAI_RSP_STATS_EN
  logic [15:0] r_stat_if, r_stat_dm;
  logic [7:0]  r_stat_drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_if   <= '0;
      r_stat_dm   <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_if_push && r_stat_if   != '1) r_stat_if   <= r_stat_if + 1'b1;
      if (w_dm_push && r_stat_dm   != '1) r_stat_dm   <= r_stat_dm + 1'b1;
      if (w_drop    && r_stat_drop != '1) r_stat_drop <= r_stat_drop + 1'b1;
    end
  end

  assign bus.oStat_IFBeats = r_stat_if;
  assign bus.oStat_DMBeats = r_stat_dm;
  assign bus.oStat_Drops   = r_stat_drop;
`endif
endmodule
